// File: rtl/spi_fifo_transmitter.sv
// Buffered SPI transmitter for a 24-bit DAC: a first-word-fall-through FIFO
// feeds a shift engine that sends one MSB-first frame per popped word.
module spi_fifo_transmitter #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 5,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_data,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  empty,
   input  logic                  start_transmit,
   output logic                  spi_busy,
   output logic                  sdo,
   output logic                  sclk,
   output logic                  sync_n
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_head;

   state_t                r_state;
   state_t                w_state_nx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_nx;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_bit_cnt_nx;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [GAP_W-1:0]      w_gap_cnt_nx;
   logic                  r_sync_n;
   logic                  w_sync_n_nx;
   logic                  r_busy;
   logic                  w_busy_nx;
   logic                  r_sclk_en;

   assign empty  = (r_wr_ptr == r_rd_ptr);
   assign full   = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
   assign w_push = write_data & ~full;
   assign w_head = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
         end
         if (w_pop && !empty) begin
            r_rd_ptr <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_sync_n  <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_shift   <= w_shift_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_gap_cnt <= w_gap_cnt_nx;
         r_sync_n  <= w_sync_n_nx;
         r_busy    <= w_busy_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_shift_nx   = r_shift;
      w_bit_cnt_nx = r_bit_cnt;
      w_gap_cnt_nx = r_gap_cnt;
      w_sync_n_nx  = r_sync_n;
      w_busy_nx    = r_busy;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sync_n_nx = 1'b1;
            w_busy_nx   = 1'b0;
            if (start_transmit && !empty) begin
               w_pop        = 1'b1;
               w_shift_nx   = w_head;
               w_sync_n_nx  = 1'b0;
               w_busy_nx    = 1'b1;
               w_bit_cnt_nx = CNT_W'(DATA_WIDTH - 1);
               w_state_nx   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_bit_cnt == '0) begin
               // Clearing the shifter forces sdo low for the whole gap.
               w_shift_nx   = '0;
               w_sync_n_nx  = 1'b1;
               w_gap_cnt_nx = GAP_W'(GAP_CYCLES);
               w_state_nx   = S_GAP;
            end else begin
               w_shift_nx   = {r_shift[DATA_WIDTH-2:0], 1'b0};
               w_bit_cnt_nx = r_bit_cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap_cnt <= GAP_W'(1)) begin
               w_busy_nx  = 1'b0;
               w_state_nx = S_IDLE;
            end else begin
               w_gap_cnt_nx = r_gap_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nx  = S_IDLE;
            w_sync_n_nx = 1'b1;
            w_busy_nx   = 1'b0;
         end
      endcase
   end

   // Enable changes only while clock is low, so the AND gate cannot glitch.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         r_sclk_en <= 1'b0;
      end else begin
         r_sclk_en <= ~r_sync_n;
      end
   end

   assign sclk     = clock & r_sclk_en;
   assign sdo      = r_shift[DATA_WIDTH-1];
   assign sync_n   = r_sync_n;
   assign spi_busy = r_busy;

endmodule

// File: tb/tb_spi_fifo_transmitter.sv
// Directed bench for spi_fifo_transmitter: words pushed into a scoreboard
// queue are compared against frames deserialised from sdo/sync_n.
module tb_spi_fifo_transmitter;

   logic        clock = 1'b0;
   logic        reset;
   logic        write_data;
   logic [23:0] data_in;
   logic        full;
   logic        empty;
   logic        start_transmit;
   logic        spi_busy;
   logic        sdo;
   logic        sclk;
   logic        sync_n;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] exp_q[$];

   spi_fifo_transmitter #(
      .DATA_WIDTH(24),
      .ADDR_WIDTH(5),
      .GAP_CYCLES(2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .write_data    (write_data),
      .data_in       (data_in),
      .full          (full),
      .empty         (empty),
      .start_transmit(start_transmit),
      .spi_busy      (spi_busy),
      .sdo           (sdo),
      .sclk          (sclk),
      .sync_n        (sync_n)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [23:0] w);
      @(posedge clock);
      #1;
      write_data = 1'b1;
      data_in    = w;
      if (exp_q.size() < 32) exp_q.push_back(w);
      @(posedge clock);
      #1;
      write_data = 1'b0;
   endtask

   // Waits for a frame, samples sdo mid-bit, and checks it against the queue.
   // drop_at: bit at which start_transmit is released; rst_at: bit during
   // which reset is asserted (frame is then abandoned).
   task automatic recv(input string tag, input int drop_at, input int rst_at, output int gap);
      logic [23:0] got;
      logic [23:0] expw;
      int          waited;
      int          n_low;
      got    = '0;
      gap    = 0;
      waited = 0;
      n_low  = 0;
      do begin
         @(negedge clock);
         waited++;
         if (sync_n !== 1'b0) gap++;
      end while (sync_n !== 1'b0 && waited < 300);
      if (sync_n !== 1'b0) begin
         chk({tag, "_start_timeout"}, 32'(sync_n), 32'd0);
         return;
      end
      chk({tag, "_busy"}, 32'(spi_busy), 32'd1);
      for (int i = 0; i < 24; i++) begin
         if (rst_at == 23 - i) begin
            @(posedge clock);
            #2;
            reset = 1'b0;
            #1;
            chk({tag, "_rst_sync_n"}, 32'(sync_n), 32'd1);
            chk({tag, "_rst_sdo"}, 32'(sdo), 32'd0);
            chk({tag, "_rst_sclk"}, 32'(sclk), 32'd0);
            chk({tag, "_rst_busy"}, 32'(spi_busy), 32'd0);
            chk({tag, "_rst_empty"}, 32'(empty), 32'd1);
            chk({tag, "_rst_full"}, 32'(full), 32'd0);
            exp_q.delete();
            return;
         end
         if (i > 0) @(negedge clock);
         if (sync_n === 1'b0) n_low++;
         got = {got[22:0], sdo};
         if (drop_at == 23 - i) start_transmit = 1'b0;
      end
      @(negedge clock);
      chk({tag, "_len"}, 32'(n_low), 32'd24);
      chk({tag, "_end_sync_n"}, 32'(sync_n), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_unexpected_frame"}, 32'(got), 32'hFFFFFFFF);
      end else begin
         expw = exp_q.pop_front();
         chk({tag, "_data"}, 32'(got), 32'(expw));
      end
   endtask

   initial begin
      int gap;
      int bad;
      reset          = 1'b0;
      write_data     = 1'b0;
      data_in        = '0;
      start_transmit = 1'b0;

      repeat (3) @(negedge clock);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_sync_n", 32'(sync_n), 32'd1);
      chk("reset_sdo", 32'(sdo), 32'd0);
      chk("reset_sclk", 32'(sclk), 32'd0);
      chk("reset_busy", 32'(spi_busy), 32'd0);
      reset = 1'b1;

      start_transmit = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (sync_n !== 1'b1 || sclk !== 1'b0) bad++;
      end
      chk("empty_no_frame", 32'(bad), 32'd0);
      chk("empty_no_busy", 32'(spi_busy), 32'd0);
      chk("empty_still_empty", 32'(empty), 32'd1);
      start_transmit = 1'b0;

      repeat (3) push(24'hEA3A35);
      chk("preload_not_empty", 32'(empty), 32'd0);
      @(negedge clock);
      start_transmit = 1'b1;
      for (int k = 0; k < 3; k++) begin
         recv("b2b", -1, -1, gap);
         if (k > 0) chk("b2b_gap", 32'(gap >= 2), 32'd1);
      end
      repeat (4) @(negedge clock);
      chk("b2b_done_empty", 32'(empty), 32'd1);
      chk("b2b_done_sync_n", 32'(sync_n), 32'd1);
      chk("b2b_done_busy", 32'(spi_busy), 32'd0);
      start_transmit = 1'b0;

      for (int k = 0; k < 32; k++) push(24'h100000 + 24'(k));
      chk("fill_full", 32'(full), 32'd1);
      push(24'hBADBAD);
      chk("overfill_full", 32'(full), 32'd1);
      @(negedge clock);
      start_transmit = 1'b1;
      for (int k = 0; k < 32; k++) recv("drain", -1, -1, gap);
      repeat (4) @(negedge clock);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_full", 32'(full), 32'd0);

      fork
         begin
            for (int k = 1; k <= 40; k++) begin
               push(24'(k));
               repeat ($urandom_range(20, 50)) @(posedge clock);
            end
         end
         begin
            for (int k = 0; k < 40; k++) recv("wrap", -1, -1, gap);
         end
      join
      repeat (4) @(negedge clock);
      chk("wrap_empty", 32'(empty), 32'd1);

      start_transmit = 1'b0;
      push(24'h5A5A5A);
      push(24'hC3C3C3);
      @(negedge clock);
      start_transmit = 1'b1;
      recv("drop", 10, -1, gap);
      bad = 0;
      repeat (40) begin
         @(negedge clock);
         if (sync_n !== 1'b1) bad++;
      end
      chk("drop_no_frame", 32'(bad), 32'd0);
      chk("drop_word_kept", 32'(empty), 32'd0);
      start_transmit = 1'b1;
      recv("resume", -1, -1, gap);

      start_transmit = 1'b0;
      push(24'h123456);
      push(24'h654321);
      @(negedge clock);
      start_transmit = 1'b1;
      recv("rst", -1, 12, gap);
      @(negedge clock);
      reset = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clock);
         if (sync_n !== 1'b1) bad++;
      end
      chk("post_rst_no_frame", 32'(bad), 32'd0);
      chk("post_rst_empty", 32'(empty), 32'd1);
      start_transmit = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
